i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 183 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C slave with a single 7-bit address: byte writes land on rx_data/rx_valid,
// byte reads are fed from tx_data with a tx_next handshake. SDA is open-drain.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_c,
  inout  wire        s_d,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_next,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t     state_q, state_d;
  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_sh_q, scl_sh_d;
  logic [2:0] sda_sh_q, sda_sh_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_next_q, tx_next_d;
  logic       busy_q, busy_d;

  logic scl_rise, scl_fall, scl_hi, start_det, stop_det, sda_in;

  assign scl_rise  = scl_sh_q[1] & ~scl_sh_q[2];
  assign scl_fall  = ~scl_sh_q[1] & scl_sh_q[2];
  assign scl_hi    = scl_sh_q[1] & scl_sh_q[2];
  assign start_det = scl_hi & sda_sh_q[2] & ~sda_sh_q[1];
  assign stop_det  = scl_hi & ~sda_sh_q[2] & sda_sh_q[1];
  assign sda_in    = sda_sh_q[1];

  assign s_d      = oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_next  = tx_next_q;
  assign busy     = busy_q;

  always_comb begin
    scl_sh_d   = {scl_sh_q[1:0], s_c};
    sda_sh_d   = {sda_sh_q[1:0], s_d};
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_next_d  = 1'b0;

    if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_in};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = shift_q[0];
              oe_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d    = RD_DATA;
              tx_shift_d = tx_data;
              tx_next_d  = 1'b1;
              oe_d       = ~tx_data[7];
            end else begin
              state_d = WR_DATA;
              oe_d    = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_in};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d    = WR_ACK;
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            oe_d       = 1'b1;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_DATA;
            cnt_d   = '0;
            oe_d    = 1'b0;
          end
        end
        // cnt counts falling edges after the MSB was put on the bus
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              state_d = RD_ACK;
              cnt_d   = '0;
              oe_d    = 1'b0;
            end else begin
              cnt_d      = cnt_q + 4'd1;
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              oe_d       = ~tx_shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_in) state_d = IGNORE;
            else        cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d    = RD_DATA;
            cnt_d      = '0;
            tx_shift_d = tx_data;
            tx_next_d  = 1'b1;
            oe_d       = ~tx_data[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scl_sh_q   <= '1;
      sda_sh_q   <= '1;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_next_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sh_q   <= scl_sh_d;
      sda_sh_q   <= sda_sh_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      tx_next_q  <= tx_next_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, transaction-level reference model,
// directed scenarios followed by randomized read/write transactions.
module tb_i2c_slave;

  localparam int T = 50;  // quarter SCL period; clk period is 10

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_next, busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_c      (scl),
    .s_d      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_next  (tx_next),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rxv_cnt = 0;
  int txn_cnt = 0;
  int slv_low_cnt = 0;

  always @(posedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (tx_next)  txn_cnt <= txn_cnt + 1;
  end

  // SDA low while the master is not pulling it means the slave is driving
  always @(negedge clk)
    if (!m_low && sda === 1'b0) slv_low_cnt <= slv_low_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the slave answers address 0x50, keeps the last accepted write
  logic [7:0] model_rx = 8'h00;
  function automatic bit model_match(input logic [7:0] addr_byte);
    return addr_byte[7:1] == 7'h50;
  endfunction

  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];

  task automatic bus_bit(input bit b, output bit seen);
    m_low = !b; #T;
    scl = 1'b1; #T;
    seen = (sda === 1'b1);
    #T;
    scl = 1'b0; #T;
  endtask

  task automatic bus_start;
    m_low = 1'b0; #T;
    scl = 1'b1; #T;
    m_low = 1'b1; #T;
    scl = 1'b0; #T;
  endtask

  task automatic bus_stop;
    m_low = 1'b1; #T;
    scl = 1'b1; #T;
    m_low = 1'b0; #T;
    #T;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acked);
    bit s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    acked = !s;
  endtask

  task automatic recv_byte(output logic [7:0] b, input bit ack, input logic [7:0] next_tx);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    tx_data = next_tx;
    bus_bit(!ack, s);
  endtask

  task automatic do_write(input logic [7:0] ab, input int n);
    bit a;
    bit exp;
    int rxv0, low0;
    rxv0 = rxv_cnt;
    low0 = slv_low_cnt;
    exp  = model_match(ab);
    bus_start;
    send_byte(ab, a);
    check("wr_addr_ack", 32'(a), 32'(exp));
    check("wr_busy", 32'(busy), 32'(exp));
    for (int k = 0; k < n; k++) begin
      send_byte(wbuf[k], a);
      check("wr_data_ack", 32'(a), 32'(exp));
      if (exp) model_rx = wbuf[k];
      check("wr_rx_data", 32'(rx_data), 32'(model_rx));
    end
    bus_stop;
    check("wr_busy_stop", 32'(busy), 32'd0);
    check("wr_rxv_count", 32'(rxv_cnt - rxv0), exp ? 32'(n) : 32'd0);
    if (!exp) check("wr_no_pull", 32'(slv_low_cnt - low0), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] ab, input int n);
    bit a;
    bit exp;
    int txn0;
    logic [7:0] b;
    txn0 = txn_cnt;
    exp  = model_match(ab);
    tx_data = rbuf[0];
    bus_start;
    send_byte(ab, a);
    check("rd_addr_ack", 32'(a), 32'(exp));
    for (int k = 0; k < n; k++) begin
      recv_byte(b, k < n - 1, rbuf[k + 1]);
      check("rd_byte", 32'(b), exp ? 32'(rbuf[k]) : 32'hFF);
    end
    check("rd_released", 32'(sda === 1'b1), 32'd1);
    bus_stop;
    check("rd_txnext_count", 32'(txn_cnt - txn0), exp ? 32'(n) : 32'd0);
    check("rd_busy_stop", 32'(busy), 32'd0);
  endtask

  initial begin
    bit a;
    bit s;
    int rxv0, low0;

    // reset values
    #22;
    check("rst_sda", 32'(sda === 1'b1), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_next", 32'(tx_next), 32'd0);
    rst_n = 1'b1;
    #(2 * T);

    // write 0x5A to our address
    wbuf[0] = 8'h5A;
    do_write(8'hA0, 1);

    // wrong address: never ACKed, nothing received
    wbuf[0] = 8'h11;
    do_write(8'hA2, 1);

    // read 0xC3, master NACKs
    rbuf[0] = 8'hC3;
    rbuf[1] = 8'h00;
    do_read(8'hA1, 1);

    // repeated START after half a written byte
    rxv0 = rxv_cnt;
    bus_start;
    send_byte(8'hA0, a);
    check("rs_addr_ack", 32'(a), 32'd1);
    bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
    rbuf[0] = 8'h96;
    rbuf[1] = 8'h00;
    do_read(8'hA1, 1);
    check("rs_no_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);

    // reset asserted during bit 4 of a written byte
    bus_start;
    send_byte(8'hA0, a);
    check("mr_addr_ack", 32'(a), 32'd1);
    bus_bit(1'b1, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
    m_low = 1'b0; #T;
    scl = 1'b1; #(T / 2);
    rst_n = 1'b0;
    #1;
    model_rx = 8'h00;
    check("mr_sda_released", 32'(sda === 1'b1), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_rx_data", 32'(rx_data), 32'h00);
    #(T / 2 - 1);
    scl = 1'b0; #T;
    rst_n = 1'b1;
    rxv0 = rxv_cnt;
    low0 = slv_low_cnt;
    for (int i = 0; i < 4; i++) bus_bit(1'b0, s);
    bus_bit(1'b1, s);
    check("mr_no_ack", 32'(s), 32'd1);
    check("mr_no_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);
    check("mr_no_pull", 32'(slv_low_cnt - low0), 32'd0);
    bus_stop;
    wbuf[0] = 8'h3C;
    do_write(8'hA0, 1);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      bit match, rw;
      logic [6:0] a7;
      int n;
      match = ($urandom_range(0, 3) != 0);
      a7    = match ? 7'h50 : (7'h50 ^ 7'($urandom_range(1, 127)));
      rw    = 1'($urandom_range(0, 1));
      n     = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        wbuf[k] = 8'($urandom);
        rbuf[k] = 8'($urandom);
      end
      if (rw) do_read({a7, 1'b1}, n);
      else    do_write({a7, 1'b0}, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
